// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller: active-low segment patterns
// (a..g, MSB first) and bit positions within the 8-bit seg bus.
package ssd_pkg;

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0000100;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b1100000;
   localparam logic [6:0] SEG_C = 7'b0110001;
   localparam logic [6:0] SEG_D = 7'b1000010;
   localparam logic [6:0] SEG_E = 7'b0110000;
   localparam logic [6:0] SEG_F = 7'b0111000;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Bit positions on the 8-bit seg bus; SEG_A..SEG_F above name hex patterns.
   localparam int unsigned SEG_IDX_A  = 7;
   localparam int unsigned SEG_IDX_B  = 6;
   localparam int unsigned SEG_IDX_C  = 5;
   localparam int unsigned SEG_IDX_D  = 4;
   localparam int unsigned SEG_IDX_E  = 3;
   localparam int unsigned SEG_IDX_F  = 2;
   localparam int unsigned SEG_IDX_G  = 1;
   localparam int unsigned SEG_DP     = 0;

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Host-side bundle of the scan controller: load handshake, live display controls and
// the registered segment/anode drive.
interface ssd_scan_ctrl_if #(
   parameter int unsigned DIGITS = 4
);

   logic                  load;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     dp_in;
   logic [DIGITS-1:0]     digit_en;
   logic                  lz_suppress;
   logic                  pending;
   logic                  frame_tick;
   logic [7:0]            seg;
   logic [DIGITS-1:0]     ssd_ctl;

   modport master (
      output load, value, dp_in, digit_en, lz_suppress,
      input  pending, frame_tick, seg, ssd_ctl
   );

   modport slave (
      input  load, value, dp_in, digit_en, lz_suppress,
      output pending, frame_tick, seg, ssd_ctl
   );

endinterface

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low a..g segment pattern.
module ssd_hex_decoder
   import ssd_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_8;
      case (hex)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_8;
      endcase
   end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed common-anode display scanner with per-slot blanking, leading-zero
// suppression and a frame-synchronous double buffer.
module ssd_scan_ctrl
   import ssd_pkg::*;
#(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned REFRESH_CNT = 100000,
   parameter int unsigned BLANK_CYC   = 1000
) (
   input  logic           clk,
   input  logic           rst_n,
   ssd_scan_ctrl_if.slave bus
);

   localparam int unsigned CntW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
   localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CntW-1:0] CntLast  = CntW'(REFRESH_CNT - 1);
   localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYC);
   localparam logic [IdxW-1:0] IdxLast  = IdxW'(DIGITS - 1);

   logic [CntW-1:0]        cnt_q;
   logic [IdxW-1:0]        idx_q;
   logic [DIGITS-1:0][3:0] disp_val_q, pend_val_q;
   logic [DIGITS-1:0]      disp_dp_q, pend_dp_q;
   logic                   pending_q, frame_tick_q;
   logic [7:0]             seg_q, seg_d;
   logic [DIGITS-1:0]      ssd_ctl_q, ssd_ctl_d;

   logic                   slot_end, fw;
   logic [DIGITS-1:0]      lz_mask;
   logic [6:0]             dec_seg;

   assign slot_end = (cnt_q == CntLast);
   assign fw       = slot_end && (idx_q == IdxLast);

   // A digit is a suppressible leading zero when it and every digit to its left are zero.
   for (genvar k = 0; k < DIGITS; k++) begin : g_lz
      if (k == 0) begin : g_lsd
         assign lz_mask[k] = 1'b0;
      end else begin : g_upper
         assign lz_mask[k] = (disp_val_q[DIGITS-1:k] == '0);
      end
   end

   ssd_hex_decoder u_dec (
      .hex (disp_val_q[idx_q]),
      .seg (dec_seg)
   );

   always_comb begin
      seg_d     = SEG_BLANK;
      ssd_ctl_d = '1;
      if ((cnt_q >= BlankEnd) && bus.digit_en[idx_q] &&
          !(bus.lz_suppress && lz_mask[idx_q])) begin
         seg_d[SEG_IDX_A:SEG_IDX_G] = dec_seg;
         seg_d[SEG_DP]              = ~disp_dp_q[idx_q];
         ssd_ctl_d[idx_q]           = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         pending_q    <= 1'b0;
         frame_tick_q <= 1'b0;
         seg_q        <= SEG_BLANK;
         ssd_ctl_q    <= '1;
      end else begin
         cnt_q <= slot_end ? '0 : cnt_q + 1'b1;
         if (slot_end) begin
            idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
         end

         // A load landing on the frame wrap bypasses the pending buffer entirely.
         if (bus.load && fw) begin
            disp_val_q <= bus.value;
            disp_dp_q  <= bus.dp_in;
            pending_q  <= 1'b0;
         end else if (bus.load) begin
            pend_val_q <= bus.value;
            pend_dp_q  <= bus.dp_in;
            pending_q  <= 1'b1;
         end else if (fw && pending_q) begin
            disp_val_q <= pend_val_q;
            disp_dp_q  <= pend_dp_q;
            pending_q  <= 1'b0;
         end

         frame_tick_q <= fw;
         seg_q        <= seg_d;
         ssd_ctl_q    <= ssd_ctl_d;
      end
   end

   assign bus.pending    = pending_q;
   assign bus.frame_tick = frame_tick_q;
   assign bus.seg        = seg_q;
   assign bus.ssd_ctl    = ssd_ctl_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl (4 digits, 8-cycle slots, 2-cycle blank) with a
// per-slot expectation queue filled when each value is loaded.
module tb_ssd_scan_ctrl;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned REFR   = 8;
   localparam int unsigned BLANK  = 2;
   localparam int unsigned FRAME  = DIGITS * REFR;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   // Each entry: lit-phase {ssd_ctl, seg} for one digit slot.
   logic [11:0] sb[$];

   ssd_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

   ssd_scan_ctrl #(
      .DIGITS      (DIGITS),
      .REFRESH_CNT (REFR),
      .BLANK_CYC   (BLANK)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] exp_dec(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0000001;
         4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;
         4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;
         4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;
         4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0000100;
         4'hA: return 7'b0001000;
         4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;
         4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

   function automatic void push_frame(input logic [15:0] v, input logic [3:0] dp,
                                      input logic [3:0] en, input logic lz);
      for (int k = 0; k < 4; k++) begin
         logic [3:0] nib;
         logic       dark;
         nib  = 4'(v >> (4 * k));
         dark = (((en >> k) & 4'h1) == 4'h0) || (lz && (k > 0) && ((v >> (4 * k)) == 16'h0));
         if (dark) sb.push_back(12'hFFF);
         else sb.push_back({~(4'b0001 << k), exp_dec(nib), ~((dp >> k) & 4'h1) == 4'hF});
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_load(input logic [15:0] v, input logic [3:0] dp);
      bus.value = v;
      bus.dp_in = dp;
      bus.load  = 1'b1;
   endtask

   // Called at a frame boundary; checks the next 32 samples. pend_from = first sample with
   // pending expected high; mid_at > 0 issues a load after that sample.
   task automatic check_frame(input int pend_from, input int mid_at,
                              input logic [15:0] mid_val, input logic [3:0] mid_dp);
      logic [11:0] exp_s [4];
      logic [11:0] exp;
      int          pos;
      int          slot;
      for (int k = 0; k < 4; k++) begin
         if (sb.size() > 0) exp_s[k] = sb.pop_front();
         else exp_s[k] = 12'h000;
      end
      for (int j = 1; j <= FRAME; j++) begin
         @(negedge clk);
         pos  = j - 1;
         slot = pos / REFR;
         exp  = ((pos % REFR) < BLANK) ? 12'hFFF : exp_s[slot[1:0]];
         chk("scan", {bus.ssd_ctl, bus.seg}, exp);
         chk("pending", bus.pending, (j >= pend_from) && (j < FRAME));
         chk("frame_tick", bus.frame_tick, j == FRAME);
         bus.load = 1'b0;
         if (j == mid_at) start_load(mid_val, mid_dp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n           = 1'b0;
      bus.load        = 1'b0;
      bus.value       = '0;
      bus.dp_in       = '0;
      bus.digit_en    = 4'hF;
      bus.lz_suppress = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_seg", bus.seg, 8'hFF);
      chk("rst_ctl", bus.ssd_ctl, 4'hF);
      chk("rst_pending", bus.pending, 1'b0);
      chk("rst_tick", bus.frame_tick, 1'b0);

      // Basic scan: reset display (all zeros) then 12A0.
      rst_n = 1'b1;
      start_load(16'h12A0, 4'h0);
      push_frame(16'h0000, 4'h0, 4'hF, 1'b0);
      check_frame(1, 0, 16'h0, 4'h0);
      push_frame(16'h12A0, 4'h0, 4'hF, 1'b0);
      check_frame(99, 0, 16'h0, 4'h0);

      // Leading-zero suppression.
      bus.lz_suppress = 1'b1;
      start_load(16'h0050, 4'h0);
      push_frame(16'h12A0, 4'h0, 4'hF, 1'b1);
      check_frame(1, 0, 16'h0, 4'h0);
      start_load(16'h0000, 4'h0);
      push_frame(16'h0050, 4'h0, 4'hF, 1'b1);
      check_frame(1, 0, 16'h0, 4'h0);

      // Mid-frame load stays pending until the wrap.
      push_frame(16'h0000, 4'h0, 4'hF, 1'b1);
      check_frame(11, 10, 16'hFFFF, 4'h0);

      // Last load in a frame wins.
      start_load(16'h1111, 4'h0);
      push_frame(16'hFFFF, 4'h0, 4'hF, 1'b1);
      check_frame(1, 12, 16'h2222, 4'h0);

      // Load on the wrap cycle commits directly.
      push_frame(16'h2222, 4'h0, 4'hF, 1'b1);
      check_frame(99, 31, 16'h3210, 4'h0);

      // Digit enables and decimal point.
      bus.lz_suppress = 1'b0;
      bus.digit_en    = 4'b0101;
      start_load(16'h8888, 4'b0001);
      push_frame(16'h3210, 4'h0, 4'b0101, 1'b0);
      check_frame(1, 0, 16'h0, 4'h0);
      push_frame(16'h8888, 4'b0001, 4'b0101, 1'b0);
      check_frame(99, 0, 16'h0, 4'h0);

      // Reset during the lit phase of digit 2 discards the pending value.
      start_load(16'hAAAA, 4'h0);
      for (int j = 1; j <= 2 * int'(REFR) + 3; j++) begin
         @(negedge clk);
         bus.load = 1'b0;
         if (j == 1) chk("pre_rst_pending", bus.pending, 1'b1);
      end
      chk("pre_rst_lit", {bus.ssd_ctl, bus.seg}, {4'b1011, 8'h01});
      rst_n = 1'b0;
      #1;
      chk("async_rst_seg", bus.seg, 8'hFF);
      chk("async_rst_ctl", bus.ssd_ctl, 4'hF);
      chk("async_rst_pending", bus.pending, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      push_frame(16'h0000, 4'h0, 4'b0101, 1'b0);
      check_frame(99, 0, 16'h0, 4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
